// File: rtl/bypass_network_pkg.sv
// Backend-wide constants and the writeback history entry type shared by the
// read-side bypass network.
package bypass_network_pkg;

  localparam int RF_WR_LAT    = 2;
  localparam int BN_PREG_W    = 7;
  localparam int BN_DATA_W    = 64;
  localparam int BN_HIST      = RF_WR_LAT;
  localparam bit BN_ZERO_PREG = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [BN_PREG_W-1:0] rd;
    logic [BN_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/bypass_network_prio_sel.sv
// Priority match of one read address against N ordered candidates; the
// lowest candidate index wins.
module bypass_prio_sel #(
  parameter int N      = 12,
  parameter int PREG_W = 7,
  parameter int DATA_W = 64
) (
  input  logic [PREG_W-1:0]   i_addr,
  input  logic [N-1:0]        i_vld,
  input  logic [N*PREG_W-1:0] i_rd,
  input  logic [N*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_hit
);

  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch.
    o_data = '0;
    o_hit  = 1'b0;
    // Scan oldest to youngest so the lowest matching index is written last.
    for (int n = N - 1; n >= 0; n--) begin
      if (i_vld[n] && (i_rd[n*PREG_W +: PREG_W] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_data[n*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/bypass_network.sv
// Read-side operand bypass: forwards current and recent writebacks that the
// multi-cycle-write regfile cannot show yet, with per-port hold and hit count.
module bypass_network
  import bypass_network_pkg::*;
#(
  parameter int READ_PORTS = 4,
  parameter int WB_PORTS   = 4,
  parameter int PREG_W     = BN_PREG_W,
  parameter int DATA_W     = BN_DATA_W,
  parameter int HIST       = BN_HIST,
  parameter bit ZERO_PREG  = BN_ZERO_PREG,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [READ_PORTS*PREG_W-1:0]   raddr,
  input  logic [READ_PORTS-1:0]          hold,
  output logic [READ_PORTS*PREG_W-1:0]   rf_raddr,
  input  logic [READ_PORTS*DATA_W-1:0]   rf_rdata,
  input  logic [WB_PORTS-1:0]            wb_en,
  input  logic [WB_PORTS-1:0]            wb_we,
  input  logic [WB_PORTS*PREG_W-1:0]     wb_rd,
  input  logic [WB_PORTS*DATA_W-1:0]     wb_res,
  output logic [READ_PORTS*DATA_W-1:0]   rdata,
  output logic [READ_PORTS-1:0]          fwd_hit,
  output logic [CNT_W-1:0]               hit_cnt
);

  localparam int N_CAND = (HIST + 1) * WB_PORTS;

  logic [READ_PORTS-1:0][PREG_W-1:0] r_raddr_q;
  wb_entry_t                         r_hist [HIST][WB_PORTS];
  wb_entry_t [WB_PORTS-1:0]          w_wb_cur;
  logic [N_CAND-1:0]                 w_cand_vld;
  logic [N_CAND-1:0][PREG_W-1:0]     w_cand_rd;
  logic [N_CAND-1:0][DATA_W-1:0]     w_cand_data;
  logic [READ_PORTS-1:0][DATA_W-1:0] w_sel_data;
  logic [READ_PORTS-1:0]             w_sel_hit;
  logic [CNT_W-1:0]                  r_hit_cnt;
  logic [CNT_W-1:0]                  w_pop;
  logic [CNT_W:0]                    w_cnt_sum;
  logic                              w_dup_wb;

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      w_wb_cur[p].valid = wb_en[p] & wb_we[p];
      w_wb_cur[p].rd    = wb_rd[p*PREG_W +: PREG_W];
      w_wb_cur[p].data  = wb_res[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_raddr_q <= '0;
    end else begin
      for (int i = 0; i < READ_PORTS; i++) begin
        if (!hold[i]) r_raddr_q[i] <= raddr[i*PREG_W +: PREG_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      rf_raddr[i*PREG_W +: PREG_W] = hold[i] ? r_raddr_q[i] : raddr[i*PREG_W +: PREG_W];
    end
  end

  // History slides every cycle, independent of hold.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      r_hist[0][p] <= w_wb_cur[p];
      for (int k = 1; k < HIST; k++) begin
        r_hist[k][p] <= r_hist[k-1][p];
      end
    end
    // NOTE: only the valid bits are reset; rd/data are never used while invalid.
    if (rst) begin
      for (int k = 0; k < HIST; k++) begin
        for (int p = 0; p < WB_PORTS; p++) begin
          r_hist[k][p].valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      w_cand_vld[p]  = w_wb_cur[p].valid;
      w_cand_rd[p]   = w_wb_cur[p].rd;
      w_cand_data[p] = w_wb_cur[p].data;
    end
    for (int k = 0; k < HIST; k++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        w_cand_vld[(k+1)*WB_PORTS + p]  = r_hist[k][p].valid;
        w_cand_rd[(k+1)*WB_PORTS + p]   = r_hist[k][p].rd;
        w_cand_data[(k+1)*WB_PORTS + p] = r_hist[k][p].data;
      end
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
    bypass_prio_sel #(
      .N      (N_CAND),
      .PREG_W (PREG_W),
      .DATA_W (DATA_W)
    ) u_sel (
      .i_addr (r_raddr_q[i]),
      .i_vld  (w_cand_vld),
      .i_rd   (w_cand_rd),
      .i_data (w_cand_data),
      .o_data (w_sel_data[i]),
      .o_hit  (w_sel_hit[i])
    );
  end

  always_comb begin
    rdata   = '0;
    fwd_hit = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (ZERO_PREG && (r_raddr_q[i] == '0)) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        fwd_hit[i]                = 1'b0;
      end else if (w_sel_hit[i]) begin
        rdata[i*DATA_W +: DATA_W] = w_sel_data[i];
        fwd_hit[i]                = 1'b1;
      end else begin
        rdata[i*DATA_W +: DATA_W] = rf_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      w_pop = w_pop + CNT_W'(fwd_hit[i]);
    end
    w_cnt_sum = {1'b0, r_hit_cnt} + {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_hit_cnt <= '0;
    else if (w_cnt_sum[CNT_W]) r_hit_cnt <= '1;
    else                     r_hit_cnt <= w_cnt_sum[CNT_W-1:0];
  end

  assign hit_cnt = r_hit_cnt;

  // Rename never issues two same-cycle writers of one live preg.
  always_comb begin
    w_dup_wb = 1'b0;
    for (int a = 0; a < WB_PORTS; a++) begin
      for (int b = a + 1; b < WB_PORTS; b++) begin
        if (w_wb_cur[a].valid && w_wb_cur[b].valid && (w_wb_cur[a].rd == w_wb_cur[b].rd)
            && !(ZERO_PREG && (w_wb_cur[a].rd == '0))) begin
          w_dup_wb = 1'b1;
        end
      end
    end
  end

  a_no_dup_wb: assert property (@(posedge clk) disable iff (rst) !w_dup_wb);

endmodule

// File: tb/tb_bypass_network.sv
// Directed bench for bypass_network: vector table for the forwarding paths,
// hand-written sequences for hold, reset and counter saturation.
module tb_bypass_network;

  localparam int RP = 4;
  localparam int WP = 4;
  localparam int PW = 7;
  localparam int DW = 64;
  localparam int CW = 5;  // small counter so saturation is reachable quickly

  logic             clk;
  logic             rst;
  logic [RP*PW-1:0] raddr;
  logic [RP-1:0]    hold;
  logic [RP*PW-1:0] rf_raddr;
  logic [RP*DW-1:0] rf_rdata;
  logic [WP-1:0]    wb_en;
  logic [WP-1:0]    wb_we;
  logic [WP*PW-1:0] wb_rd;
  logic [WP*DW-1:0] wb_res;
  logic [RP*DW-1:0] rdata;
  logic [RP-1:0]    fwd_hit;
  logic [CW-1:0]    hit_cnt;

  bypass_network #(
    .READ_PORTS (RP),
    .WB_PORTS   (WP),
    .PREG_W     (PW),
    .DATA_W     (DW),
    .HIST       (2),
    .ZERO_PREG  (1'b1),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .hold     (hold),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .wb_en    (wb_en),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_res   (wb_res),
    .rdata    (rdata),
    .fwd_hit  (fwd_hit),
    .hit_cnt  (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rp;
    logic [6:0]  ra;
    int          wp;
    logic        wen;
    logic        wwe;
    logic [6:0]  wrd;
    logic [63:0] wres;
    logic [63:0] rf;
    logic [63:0] ed;
    logic        eh;
    string       nm;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    raddr    = '0;
    hold     = '0;
    rf_rdata = '0;
    wb_en    = '0;
    wb_we    = '0;
    wb_rd    = '0;
    wb_res   = '0;
  endtask

  task automatic set_wb(input int p, input logic en, input logic we,
                        input logic [6:0] rd, input logic [63:0] res);
    wb_en[p]           = en;
    wb_we[p]           = we;
    wb_rd[p*PW +: PW]  = rd;
    wb_res[p*DW +: DW] = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int rp, input logic [6:0] ra, input int wp, input logic wen,
                     input logic wwe, input logic [6:0] wrd, input logic [63:0] wres,
                     input logic [63:0] rf, input logic [63:0] ed, input logic eh,
                     input string nm);
    vec_t v;
    v.rp = rp; v.ra = ra; v.wp = wp; v.wen = wen; v.wwe = wwe; v.wrd = wrd;
    v.wres = wres; v.rf = rf; v.ed = ed; v.eh = eh; v.nm = nm;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_cnt;

    // rp  ra     wp en we rd     res        rf         exp data   hit  name
    add(0, 7'd5,  0, 0, 0, 7'd0,  64'h0,     64'h0,     64'h0,     0, "t1_idle");
    add(0, 7'd5,  1, 1, 1, 7'd5,  64'hAA,    64'h77,    64'hAA,    1, "t1_cur");
    add(0, 7'd5,  0, 0, 0, 7'd0,  64'h0,     64'h77,    64'hAA,    1, "t1_hist0");
    add(0, 7'd5,  0, 0, 0, 7'd0,  64'h0,     64'h77,    64'hAA,    1, "t1_hist1");
    add(0, 7'd5,  0, 0, 0, 7'd0,  64'h0,     64'hAA,    64'hAA,    0, "t1_rf");
    add(1, 7'd9,  0, 1, 1, 7'd9,  64'h11,    64'h0,     64'h0,     0, "t2_wr");
    add(1, 7'd9,  0, 0, 0, 7'd0,  64'h0,     64'h0,     64'h11,    1, "t2_hist0");
    add(1, 7'd9,  0, 0, 0, 7'd0,  64'h0,     64'h0,     64'h11,    1, "t2_hist1");
    add(1, 7'd9,  0, 0, 0, 7'd0,  64'h0,     64'h11,    64'h11,    0, "t2_rf");
    add(1, 7'd10, 2, 1, 1, 7'd10, 64'h11,    64'h11,    64'h11,    0, "t3_w1");
    add(1, 7'd10, 3, 1, 1, 7'd10, 64'h22,    64'h0,     64'h22,    1, "t3_cur");
    add(1, 7'd10, 0, 0, 0, 7'd0,  64'h0,     64'h0,     64'h22,    1, "t3_young");
    add(1, 7'd10, 0, 0, 0, 7'd0,  64'h0,     64'h0,     64'h22,    1, "t3_hist1");
    add(1, 7'd10, 0, 0, 0, 7'd0,  64'h0,     64'h22,    64'h22,    0, "t3_rf");
    add(1, 7'd10, 0, 1, 0, 7'd10, 64'hDEAD,  64'h22,    64'h22,    0, "nowe_cur");
    add(1, 7'd10, 0, 0, 0, 7'd0,  64'h0,     64'h22,    64'h22,    0, "nowe_hist");
    add(1, 7'd10, 1, 0, 1, 7'd10, 64'hBEEF,  64'h22,    64'h22,    0, "noen_cur");
    add(3, 7'd0,  0, 1, 1, 7'd0,  64'hFF,    64'h99,    64'h0,     0, "t5_cur");
    add(3, 7'd0,  0, 0, 0, 7'd0,  64'h0,     64'h99,    64'h0,     0, "t5_hist");

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cnt",   64'(hit_cnt), 64'h0);
    check("rst_hit",   64'(fwd_hit), 64'h0);
    check("rst_rdata", 64'(rdata[DW-1:0]), 64'h0);
    step();

    foreach (vecs[n]) begin
      vec_t v;
      v = vecs[n];
      clear_inputs();
      raddr[v.rp*PW +: PW] = v.ra;
      set_wb(v.wp, v.wen, v.wwe, v.wrd, v.wres);
      rf_rdata[v.rp*DW +: DW] = v.rf;
      @(negedge clk);
      check({v.nm, "_data"}, rdata[v.rp*DW +: DW], v.ed);
      check({v.nm, "_hit"},  64'(fwd_hit[v.rp]), 64'(v.eh));
      check({v.nm, "_rfa"},  64'(rf_raddr[v.rp*PW +: PW]), 64'(v.ra));
      step();
    end

    // Hold port 2 on preg 3 for five cycles; a write lands in the second.
    clear_inputs();
    raddr[2*PW +: PW]    = 7'd3;
    rf_rdata[2*DW +: DW] = 64'h01;
    @(negedge clk);
    check("hold_pre_data", rdata[2*DW +: DW], 64'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      hold[2]              = 1'b1;
      raddr[2*PW +: PW]    = 7'h7F;
      if (c == 1) set_wb(0, 1'b1, 1'b1, 7'd3, 64'h33);
      rf_rdata[2*DW +: DW] = (c >= 4) ? 64'h33 : 64'h01;
      @(negedge clk);
      check($sformatf("hold%0d_data", c), rdata[2*DW +: DW], (c == 0) ? 64'h01 : 64'h33);
      check($sformatf("hold%0d_hit", c), 64'(fwd_hit[2]), (c >= 1 && c <= 3) ? 64'h1 : 64'h0);
      check($sformatf("hold%0d_rfa", c), 64'(rf_raddr[2*PW +: PW]), 64'h3);
      step();
    end
    clear_inputs();
    raddr[2*PW +: PW]    = 7'h7F;
    rf_rdata[2*DW +: DW] = 64'h33;
    @(negedge clk);
    check("unhold_data", rdata[2*DW +: DW], 64'h33);
    check("unhold_rfa",  64'(rf_raddr[2*PW +: PW]), 64'h7F);
    step();

    // Reset in the middle of traffic on preg 20.
    clear_inputs();
    raddr[0 +: PW] = 7'd20;
    set_wb(1, 1'b1, 1'b1, 7'd20, 64'h66);
    step();
    clear_inputs();
    rst            = 1'b1;
    raddr[0 +: PW] = 7'd20;
    set_wb(2, 1'b1, 1'b1, 7'd20, 64'h77);
    @(negedge clk);
    check("rstcyc_data", rdata[0 +: DW], 64'h77);
    check("rstcyc_hit",  64'(fwd_hit[0]), 64'h1);
    step();
    rst = 1'b0;
    clear_inputs();
    raddr[0 +: PW]  = 7'd20;
    rf_rdata[0 +: DW] = 64'h5;
    @(negedge clk);
    check("rstrel_data", rdata[0 +: DW], 64'h0);
    check("rstrel_cnt",  64'(hit_cnt), 64'h0);
    step();
    clear_inputs();
    for (int i = 0; i < RP; i++) raddr[i*PW +: PW] = 7'd30;
    rf_rdata[0 +: DW] = 64'h5;
    @(negedge clk);
    check("postrst_data", rdata[0 +: DW], 64'h5);
    check("postrst_hit",  64'(fwd_hit[0]), 64'h0);
    check("postrst_cnt",  64'(hit_cnt), 64'h0);
    step();

    // Four hits per cycle drive the 5-bit counter into saturation.
    exp_cnt = 64'h0;
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      for (int i = 0; i < RP; i++) raddr[i*PW +: PW] = 7'd30;
      set_wb(0, 1'b1, 1'b1, 7'd30, 64'hC0 + 64'(c));
      @(negedge clk);
      check($sformatf("sat%0d_hit", c),  64'(fwd_hit), 64'hF);
      check($sformatf("sat%0d_data", c), rdata[3*DW +: DW], 64'hC0 + 64'(c));
      check($sformatf("sat%0d_cnt", c),  64'(hit_cnt), exp_cnt);
      step();
      exp_cnt = (exp_cnt + 64'd4 > 64'd31) ? 64'd31 : exp_cnt + 64'd4;
    end
    clear_inputs();
    @(negedge clk);
    check("sat_final_cnt", 64'(hit_cnt), 64'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
